// File: rtl/sync_ram_pkg.sv
// rtl/sync_ram_pkg.sv - shared constants and helpers for sync_ram
//
// Purpose: default address/data widths for sync_ram and the depth helper
//          that turns an address width into a word count.
// Ports:   none (package).
package sync_ram_pkg;

   localparam int SYNC_RAM_ADDRESS_BITS_DEF = 1;
   localparam int SYNC_RAM_DATA_BITS_DEF    = 1;

   // Number of words addressed by an address of the given width.
   function automatic int sync_ram_depth(input int address_bits);
      return 1 << address_bits;
   endfunction

endpackage

// File: rtl/sync_ram.sv
// rtl/sync_ram.sv - single-port synchronous RAM with registered read and reset clear
//
// Purpose: 2**ADDRESS_BITS words of DATA_BITS bits. Writes and reads share one
//          address; the read port is registered (one-cycle latency) and always
//          enabled. A synchronous active-low reset clears every word and the
//          read register, and wins over a write on the same edge.
// Config:  SYNC_RAM_WRITE_FIRST_EN defined   -> write-first: a write edge returns data_in.
//          SYNC_RAM_WRITE_FIRST_EN undefined -> read-first: a write edge returns the old word.
// Ports:   clock    - sole clock, rising edge
//          reset    - synchronous reset, active low
//          write    - write enable
//          address  - word address for read and write
//          data_in  - write data
//          data_out - registered read data
module sync_ram
   import sync_ram_pkg::*;
#(
   parameter int ADDRESS_BITS = SYNC_RAM_ADDRESS_BITS_DEF,
   parameter int DATA_BITS    = SYNC_RAM_DATA_BITS_DEF
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    write,
   input  logic [ADDRESS_BITS-1:0] address,
   input  logic [DATA_BITS-1:0]    data_in,
   output logic [DATA_BITS-1:0]    data_out
);

   localparam int DEPTH = sync_ram_depth(ADDRESS_BITS);

   logic [DATA_BITS-1:0] mem [DEPTH];

   // Array and read register share one process so reset clears both on the
   // same edge; the clear loop keeps small depths mappable to plain flops.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         data_out <= '0;
      end else begin
         if (write) begin
            mem[address] <= data_in;
         end
`ifdef SYNC_RAM_WRITE_FIRST_EN
         // Forward the incoming word so a write edge returns the new data.
         data_out <= write ? data_in : mem[address];
`else
         // Non-blocking read of mem returns the word as it was before this edge.
         data_out <= mem[address];
`endif
      end
   end

endmodule

// File: tb/tb_sync_ram.sv
// tb/tb_sync_ram.sv - directed self-checking bench for sync_ram (default and 4x8 builds)
module tb_sync_ram;

   logic       clock = 1'b0;
   logic       reset;

   logic       s_write;
   logic [0:0] s_address;
   logic [0:0] s_data_in;
   logic [0:0] s_data_out;

   logic       w_write;
   logic [3:0] w_address;
   logic [7:0] w_data_in;
   logic [7:0] w_data_out;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   sync_ram u_small (
      .clock    (clock),
      .reset    (reset),
      .write    (s_write),
      .address  (s_address),
      .data_in  (s_data_in),
      .data_out (s_data_out)
   );

   sync_ram #(.ADDRESS_BITS(4), .DATA_BITS(8)) u_wide (
      .clock    (clock),
      .reset    (reset),
      .write    (w_write),
      .address  (w_address),
      .data_in  (w_data_in),
      .data_out (w_data_out)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [7:0] rdw_exp;
      logic [0:0] s_wr_exp;
`ifdef SYNC_RAM_WRITE_FIRST_EN
      rdw_exp  = 8'h5A;
      s_wr_exp = 1'b1;
`else
      rdw_exp  = 8'h11;
      s_wr_exp = 1'b0;
`endif

      reset = 1'b0;
      s_write = 1'b0; s_address = 1'b0; s_data_in = 1'b0;
      w_write = 1'b0; w_address = 4'd0; w_data_in = 8'h00;

      // Reset clear
      tick();
      tick();
      check_eq("reset_small_out", {31'd0, s_data_out}, 32'd0);
      check_eq("reset_wide_out", {24'd0, w_data_out}, 32'd0);
      reset = 1'b1;
      s_address = 1'b0;
      tick();
      check_eq("reset_rd_a0", {31'd0, s_data_out}, 32'd0);
      s_address = 1'b1;
      tick();
      check_eq("reset_rd_a1", {31'd0, s_data_out}, 32'd0);

      // Basic write/read on the default build
      s_address = 1'b0; s_data_in = 1'b1; s_write = 1'b1;
      tick();
      check_eq("small_wr_edge", {31'd0, s_data_out}, {31'd0, s_wr_exp});
      s_write = 1'b0; s_data_in = 1'b0;
      tick();
      check_eq("small_rd_a0", {31'd0, s_data_out}, 32'd1);
      s_address = 1'b1;
      tick();
      check_eq("small_rd_a1", {31'd0, s_data_out}, 32'd0);

      // Reset beats write: address 0 currently holds 1, write 1 again under reset
      reset = 1'b0; s_write = 1'b1; s_address = 1'b0; s_data_in = 1'b1;
      tick();
      check_eq("rst_wr_out", {31'd0, s_data_out}, 32'd0);
      reset = 1'b1; s_write = 1'b0; s_data_in = 1'b0;
      tick();
      check_eq("rst_wr_rd_a0", {31'd0, s_data_out}, 32'd0);

      // Read-during-write on the wide build
      w_address = 4'd3; w_data_in = 8'h11; w_write = 1'b1;
      tick();
      w_data_in = 8'h5A;
      tick();
      check_eq("rdw_edge", {24'd0, w_data_out}, {24'd0, rdw_exp});
      w_write = 1'b0; w_data_in = 8'h00;
      tick();
      check_eq("rdw_after", {24'd0, w_data_out}, 32'h5A);

      // Full sweep: back-to-back writes of addr^0xA5, then read back
      for (int a = 0; a < 16; a++) begin
         w_address = 4'(a);
         w_data_in = 8'(a) ^ 8'hA5;
         w_write   = 1'b1;
         tick();
      end
      w_write = 1'b0; w_data_in = 8'h00;
      for (int a = 0; a < 16; a++) begin
         w_address = 4'(a);
         tick();
         check_eq($sformatf("sweep_rd_%0d", a), {24'd0, w_data_out}, {24'd0, 8'(a) ^ 8'hA5});
      end

      // Mid-operation reset wipes the whole array
      w_address = 4'd7;
      reset = 1'b0;
      tick();
      check_eq("mid_rst_out", {24'd0, w_data_out}, 32'd0);
      reset = 1'b1;
      for (int a = 0; a < 16; a++) begin
         w_address = 4'(a);
         tick();
         check_eq($sformatf("mid_rst_rd_%0d", a), {24'd0, w_data_out}, 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
